adc_ram_readout: RTL and testbench
==================================

Name: adc_ram_readout

Overview:
- Drains samples that adc_capture has written into the ADC sample RAM (4096 x 32) and presents them as a valid/ready word stream to the JTAG readout logic.
- Drives the RAM read port (second port of the dual-port RAM) and absorbs the fixed RAM read latency with a small credit-controlled FIFO, so downstream backpressure never loses or duplicates a word.

Parameters:
- ADDR_W, 12, RAM address width; the address space is 2^ADDR_W words.
- DATA_W, 32, RAM and stream word width.
- RD_LATENCY, 2, cycles from ram_addr/ram_re to valid ram_rd_data (1..3).
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LATENCY+1 and a power of 2.

Ports:
- clk  in  1  system clock (160 MHz domain shared with adc_capture).
- reset_n  in  1  asynchronous, active-low reset.
- rd_start  in  1  single-cycle request to begin a readout.
- rd_base_addr  in  ADDR_W  first RAM word to read; sampled on an accepted rd_start.
- rd_length  in  ADDR_W+1  word count, 0..4096; sampled on an accepted rd_start.
- ram_addr  out  ADDR_W  RAM read address.
- ram_re  out  1  RAM read strobe; one word is issued per high cycle.
- ram_rd_data  in  DATA_W  RAM read data, valid RD_LATENCY cycles after ram_re.
- out_data  out  DATA_W  stream word (FIFO head).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_last  out  1  qualifies the final word of a readout; meaningful only while out_valid is high.
- busy  out  1  high from an accepted start until the last word is accepted.
- done  out  1  sticky; set with the final accepted word, cleared by the next accepted rd_start.

Behaviour:
- Reset (async assert, sync release): state IDLE. ram_addr=0, ram_re=0, out_valid=0, out_last=0, busy=0, done=0. FIFO empty, in-flight count 0, read pipeline flushed. Reset mid-readout aborts it with no further output.
- States:
  - IDLE: rd_start with rd_length!=0 -> ISSUE. Latch addr=rd_base_addr and remaining=rd_length; set busy=1, clear done.
  - rd_start with rd_length==0 in IDLE: no reads, no output words. busy stays 0; done is set to 1 on the following cycle.
  - ISSUE: ram_re=1 in a cycle iff remaining!=0 and (fifo_count + inflight) < FIFO_DEPTH. On each issue, addr <= addr+1 modulo 2^ADDR_W (0xFFF wraps to 0x000) and remaining decrements. When remaining reaches 0 -> DRAIN.
  - DRAIN: wait until the word tagged last is accepted, then -> IDLE. busy=0 and done=1 from the next cycle.
- rd_start while busy is ignored; the latched parameters do not change.
- Read pipeline: a RD_LATENCY-deep shift register of ram_re and a last-tag marks which returning ram_rd_data is written into the FIFO. inflight = number of set bits in that shift register.
- FIFO (first-word-fall-through): out_valid = !empty. A push and a pop in the same cycle is legal and keeps the count unchanged. Credit gating guarantees the FIFO never overflows; overflow is unreachable and is asserted against in simulation.
- ram_addr holds its last value when ram_re=0.
- Throughput: with out_ready held high, one word per cycle after an initial latency. The first out_valid appears RD_LATENCY+1 cycles after the accepted rd_start (start latch 1 cycle, then RAM latency).
- out_data and out_last must be held stable while out_valid && !out_ready.
- Exactly rd_length words are produced per readout, in address order, each exactly once.

Test Plan:
- Basic: RAM model preloaded with data[i]=0xA000_0000+i. rd_start with base=0x000, length=4, out_ready=1 -> out_data 0xA0000000..0xA0000003 on 4 consecutive cycles; out_last on the 4th word; done=1 and busy=0 the cycle after.
- Wrap: base=0xFFE, length=4 -> ram_addr sequence FFE, FFF, 000, 001; data 0xA0000FFE, 0xA0000FFF, 0xA0000000, 0xA0000001.
- Backpressure: base=0x010, length=16, out_ready toggling 1,0,0,1 repeated -> 16 words 0xA0000010..0xA000001F with no gaps or duplicates; fifo_count never exceeds 4; data stable while stalled.
- Full length: length=4096, base=0x123, out_ready=1 -> 4096 words; last word is 0xA0000122; throughput of 1 word/cycle after the pipeline fills.
- Edge starts: length=0 -> no ram_re, no out_valid, done=1. rd_start pulsed mid-readout (base=0x800) -> ignored; the original sequence completes unchanged.
- Reset mid-operation: assert reset_n=0 after 5 of 16 words -> all outputs return to 0 asynchronously. A new readout after release (base=0, length=2) produces exactly 0xA0000000 and 0xA0000001.

Source files
------------

// File: rtl/adc_ram_readout.sv
// Streams a block of words out of the ADC sample RAM as a valid/ready stream.
// A credit-gated first-word-fall-through FIFO absorbs the fixed RAM read latency.
module adc_ram_readout #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base_addr,
  input  logic [ADDR_W:0]   rd_length,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   next_addr;
  logic [ADDR_W:0]     remaining;
  logic                ram_last;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_last;

  logic [DATA_W:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       fifo_count;

  logic                push;
  logic                pop;
  logic [DATA_W:0]     head;
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       occupancy;
  logic                can_issue;

  // Credits count every word already committed: queued, in the RAM pipe, or issued
  // this cycle. A word popped this cycle frees its slot, which sustains 1 word/cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(pipe_vld[i]);
    end
    push      = pipe_vld[RD_LATENCY-1];
    head      = fifo_mem[rd_ptr];
    out_valid = (fifo_count != '0);
    pop       = out_valid && out_ready;
    out_data  = out_valid ? head[DATA_W-1:0] : '0;
    out_last  = out_valid && head[DATA_W];
    occupancy = fifo_count + inflight + CW'(ram_re) - CW'(pop);
    can_issue = (remaining != '0) && (occupancy < CW'(FIFO_DEPTH));
  end

  // Read pipeline: marks which cycles of ram_rd_data carry a requested word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      pipe_vld[0]  <= ram_re;
      pipe_last[0] <= ram_last;
    end
  end

  // NOTE: FIFO storage is not reset; the count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {pipe_last[RD_LATENCY-1], ram_rd_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always @(posedge clk) begin
    if (reset_n) assert (!(push && !pop && fifo_count == CW'(FIFO_DEPTH)));
  end

  // Control FSM. The first read issues on the same edge that accepts rd_start,
  // so the first word is visible RD_LATENCY+1 cycles after that edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ram_addr  <= '0;
      ram_re    <= 1'b0;
      ram_last  <= 1'b0;
      next_addr <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      ram_re   <= 1'b0;
      ram_last <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rd_start) begin
            if (rd_length != '0) begin
              ram_re    <= 1'b1;
              ram_addr  <= rd_base_addr;
              ram_last  <= (rd_length == (ADDR_W+1)'(1));
              next_addr <= rd_base_addr + ADDR_W'(1);
              remaining <= rd_length - (ADDR_W+1)'(1);
              busy      <= 1'b1;
              done      <= 1'b0;
              state     <= (rd_length == (ADDR_W+1)'(1)) ? DRAIN : ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (can_issue) begin
            ram_re    <= 1'b1;
            ram_addr  <= next_addr;
            ram_last  <= (remaining == (ADDR_W+1)'(1));
            next_addr <= next_addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ram_readout.sv
// Scoreboard bench for adc_ram_readout: a RAM model with fixed latency feeds the DUT,
// expected addresses and words are queued at start and checked by a negedge monitor.
module tb_adc_ram_readout;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_base_addr;
  logic [ADDR_W:0]   rd_length;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              done;

  int tests = 0;
  int fails = 0;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int                words_seen = 0;
  logic [DATA_W-1:0] last_word = '0;
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] held_data;
  logic              held_last;

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] rpipe [RD_LATENCY];

  always #5 clk = ~clk;

  adc_ram_readout #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rd_start(rd_start), .rd_base_addr(rd_base_addr),
    .rd_length(rd_length), .ram_addr(ram_addr), .ram_re(ram_re), .ram_rd_data(ram_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  // RAM read port model: data for a read issued in cycle k is presented in cycle k+RD_LATENCY.
  always @(posedge clk) begin
    rpipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LATENCY; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rd_data = rpipe[RD_LATENCY-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: checks every issued address, every accepted word, and hold-while-stalled.
  initial begin
    exp_t              e;
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, held_data);
          check("hold_last", out_last, held_last);
        end
        if (ram_re) begin
          if (addr_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL ram_re_unexpected: ram_re with addr %0h, none expected", ram_addr);
          end else begin
            a = addr_q.pop_front();
            check("ram_addr", ram_addr, a);
          end
        end
        if (out_valid && out_ready) begin
          words_seen++;
          if (out_last) last_word = out_data;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL word_unexpected: got %0h, none expected", out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_last", out_last, e.last);
          end
        end
        stall_prev = out_valid && !out_ready;
        held_data  = out_data;
        held_last  = out_last;
      end
    end
  end

  // Queues the expected reads/words, then presents a one-cycle rd_start.
  // Returns 1 time unit after the edge that accepts the start.
  task automatic start_rd(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = base + ADDR_W'(i);
      addr_q.push_back(a);
      exp_q.push_back('{data: 32'hA000_0000 + {20'd0, a}, last: (i == int'(len) - 1)});
    end
    @(posedge clk); #1;
    rd_start = 1'b1; rd_base_addr = base; rd_length = len;
    @(posedge clk); #1;
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int cycles);
    logic got;
    got = 1'b0;
    cycles = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
    end
  endtask

  initial begin
    int cyc;
    int w0;
    logic [3:0] bp_pat;
    bp_pat = 4'b1001;

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA000_0000 + i;
    reset_n = 1'b0; rd_start = 1'b0; rd_base_addr = '0; rd_length = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_re", ram_re, 0);
    check("rst_addr", ram_addr, 0);
    reset_n = 1'b1;

    // Basic: first word RD_LATENCY+1 cycles after the accepting edge, then 4 back-to-back.
    start_rd(12'h000, 13'd4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("basic_valid_c%0d", k), out_valid, (k >= 4 && k <= 7));
      if (k == 1) check("basic_busy", busy, 1);
      if (k == 7) check("basic_last_flag", out_last, 1);
      if (k == 8) begin
        check("basic_done", done, 1);
        check("basic_busy_clr", busy, 0);
      end
    end
    check("basic_q_empty", exp_q.size(), 0);

    // Wrap across the top of the address space.
    start_rd(12'hFFE, 13'd4);
    wait_done("wrap", 50, cyc);
    check("wrap_last_word", last_word, 32'hA000_0001);
    check("wrap_q_empty", exp_q.size(), 0);
    check("wrap_addr_q_empty", addr_q.size(), 0);

    // Backpressure with out_ready pattern 1,0,0,1.
    w0 = words_seen;
    start_rd(12'h010, 13'd16);
    for (int k = 0; k < 200; k++) begin
      if (done) break;
      out_ready = bp_pat[k % 4];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check("bp_done", done, 1);
    check("bp_words", words_seen - w0, 16);
    check("bp_last_word", last_word, 32'hA000_001F);
    check("bp_q_empty", exp_q.size(), 0);

    // A second rd_start mid-readout must be ignored.
    start_rd(12'h040, 13'd8);
    @(posedge clk); #1;
    rd_start = 1'b1; rd_base_addr = 12'h800; rd_length = 13'd5;
    @(posedge clk); #1;
    rd_start = 1'b0;
    wait_done("ignore", 50, cyc);
    repeat (6) @(negedge clk);
    check("ignore_last_word", last_word, 32'hA000_0047);
    check("ignore_q_empty", exp_q.size(), 0);
    check("ignore_busy", busy, 0);

    // Full address space at one word per cycle: 3 cycles latency + 4096 words + done.
    w0 = words_seen;
    start_rd(12'h123, 13'd4096);
    wait_done("full", 5000, cyc);
    check("full_cycles", cyc, 4100);
    check("full_words", words_seen - w0, 4096);
    check("full_last_word", last_word, 32'hA000_0122);
    check("full_q_empty", exp_q.size(), 0);

    // Reset in the middle of a readout.
    w0 = words_seen;
    start_rd(12'h000, 13'd16);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (words_seen - w0 >= 5) break;
    end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("arst_re", ram_re, 0);
    check("arst_addr", ram_addr, 0);
    check("arst_valid", out_valid, 0);
    check("arst_last", out_last, 0);
    check("arst_data", out_data, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_done", done, 0);
    check("post_rst_valid", out_valid, 0);

    // Zero length: no reads, no words, done next cycle, busy never set.
    start_rd(12'h000, 13'd0);
    @(negedge clk);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("len0_valid", out_valid, 0);

    // Fresh readout after reset.
    w0 = words_seen;
    start_rd(12'h000, 13'd2);
    wait_done("post_rst", 50, cyc);
    check("post_rst_words", words_seen - w0, 2);
    check("post_rst_last_word", last_word, 32'hA000_0001);
    check("post_rst_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
